moddiv_pow2_pipe: RTL
=====================

Name: moddiv_pow2_pipe

Overview:
Multi-lane pipelined modular scaler that computes y = x * 2^-k mod q, with the shift count k selectable per beat, for odd q.
It replaces single-step fixed halving in the INTT/GS butterfly path and in the final N^-1 scaling.
Each pipeline stage performs one conditional modular halving, and a valid/ready handshake gives full backpressure.
A sticky range-error flag reports any accepted operand that is not less than q.

Parameters:
LOGQ, 13, bit width of modulus and operands.
LANES, 2, independent coefficient lanes per beat; all lanes share k and q.
MAXK, 3, number of pipeline stages; maximum halvings per beat; must be >= 1.
KW, $clog2(MAXK+1), derived width of in_k; not overridden.

Ports:
clk  input  1  clock; all flops on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  input beat valid.
in_ready  output  1  block accepts a beat this cycle.
in_k  input  KW  number of halvings for this beat (0..MAXK).
in_x  input  LANES*LOGQ  operands; lane i occupies bits [i*LOGQ +: LOGQ].
q  input  LOGQ  odd modulus; quasi-static.
out_valid  output  1  output beat valid.
out_ready  input  1  downstream accepts the output beat.
out_y  output  LANES*LOGQ  results, with the same lane packing as in_x.
err  output  1  sticky flag: some accepted lane had x >= q, or a beat had in_k > MAXK.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All stage valid bits are cleared, so out_valid=0.
  - err=0 and out_y=0.
  - Stage data and k registers are cleared.
  - Reset mid-operation discards every beat in flight; nothing is emitted after release.
- Pipeline structure:
  - MAXK register stages, s=1..MAXK. Each stage holds a valid bit, a remaining-count rk, and LANES data words.
  - Stage 1 loads from the input. Stage s loads from stage s-1. out_* are driven directly from stage MAXK registers.
- Advance condition: adv = ~vld[MAXK] | out_ready.
  - When adv=1, every stage shifts by one.
  - When adv=0, all stages hold, including valid bits and data.
  - Bubbles are not collapsed.
  - in_ready = adv, as a combinational function of vld[MAXK] and out_ready.
- Handshakes:
  - An input beat is accepted iff in_valid & in_ready.
  - An output beat is consumed iff out_valid & out_ready.
  - When not accepting, stage 1 loads vld=0.
- Latency and throughput:
  - Fixed latency of exactly MAXK cycles from acceptance to out_valid when not stalled, independent of in_k.
  - Throughput is one beat per cycle.
  - Beat order is preserved.
- Per-stage operation:
  - If rk > 0: each lane computes h(x), and rk becomes rk-1.
  - Else: the word passes through unchanged.
  - h(x) = x>>1 when x[0]=0; h(x) = (x>>1) + ((q+1)>>1) when x[0]=1. The sum is LOGQ bits with no carry out, because x<q.
  - Stage 1 applies this to the raw input with rk=in_k.
- Range:
  - For x<q, every h(x)<q, so outputs are fully reduced.
  - For x>=q, the output is unspecified, but the data must not corrupt other lanes or beats.
- in_k values:
  - in_k=0 is a pure pass-through with MAXK latency.
  - in_k > MAXK is clamped to MAXK and sets err.
- err:
  - Set on any accepted beat with any lane x >= q, or with in_k > MAXK.
  - Cleared only by reset.
- q must be stable while any beat is in flight. Changing q with data in the pipe gives undefined results for those beats only.
- Simultaneous events:
  - Accept and emit in the same cycle is a normal full-throughput case.
  - out_ready dropping with the pipe full holds all data. in_ready falls in the same cycle.

Test Plan:
1. LOGQ=13, q=7681, LANES=2, MAXK=3: in_x={lane1=7680, lane0=3}, in_k=1 -> after exactly 3 cycles, out_y={3840, 3842}; err=0.
2. q=7681, x=1, in_k=3 -> out_y=6721; check that 6721*8 mod 7681 = 1. Also x=3, in_k=2 -> 1921; x=0, in_k=3 -> 0.
3. Back-to-back stream:
   - Stimulus: 20 consecutive beats with random x<q and random in_k in 0..3, out_ready=1.
   - Response: one result per cycle, in order, each equal to x*2^-k mod 7681, matched against the reference model.
4. Backpressure:
   - Stimulus: fill the pipe, then hold out_ready=0 for 5 cycles while in_valid=1.
   - Response: in_ready=0 during the stall; out_y and out_valid stable; no beat lost or duplicated after out_ready returns.
5. Error flag: accept one beat with x=7681 (=q) on lane 0 -> err=1 the next cycle and stays 1 through later valid beats. A separate beat with in_k=3 and x=5 still gives the correct result.
6. Reset mid-stream:
   - Stimulus: assert rst_n=0 asynchronously with 3 beats in flight and err=1.
   - Response: out_valid=0, err=0 and out_y=0 immediately; no stale beat is emitted after release; a new beat then has latency 3.

Source files
------------

// File: rtl/moddiv_pow2_pipe.sv
// Pipelined modular scaler: y = x * 2^-k mod q for odd q. Each stage does one
// conditional halving; a valid/ready handshake provides full backpressure.
module moddiv_pow2_pipe #(
  parameter int LOGQ  = 13,
  parameter int LANES = 2,
  parameter int MAXK  = 3,
  localparam int KW   = $clog2(MAXK + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [KW-1:0]         in_k,
  input  logic [LANES*LOGQ-1:0] in_x,
  input  logic [LOGQ-1:0]       q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*LOGQ-1:0] out_y,
  output logic                  err
);

  typedef logic [LOGQ-1:0] word_t;

  logic          vld     [MAXK];
  logic [KW-1:0] rk      [MAXK];
  word_t         dat     [MAXK][LANES];
  logic          nxt_vld [MAXK];
  logic [KW-1:0] nxt_rk  [MAXK];
  word_t         nxt_dat [MAXK][LANES];

  logic          adv;
  logic          accept;
  logic          k_over;
  logic          x_over;
  logic [KW-1:0] k_eff;
  word_t         half_q1;

  // (q+1)/2 without needing a LOGQ+1 bit sum, valid because q is odd.
  assign half_q1 = (q >> 1) + word_t'(1);

  // For x < q the sum stays below q, so no carry out of LOGQ bits.
  function automatic word_t halve(input word_t x, input word_t hq);
    return x[0] ? ((x >> 1) + hq) : (x >> 1);
  endfunction

  always_comb begin
    adv      = ~vld[MAXK-1] | out_ready;
    in_ready = adv;
    accept   = in_valid & adv;
    k_over   = 32'(in_k) > 32'(MAXK);
    k_eff    = k_over ? KW'(MAXK) : in_k;
    x_over   = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      if (in_x[l*LOGQ +: LOGQ] >= q) x_over = 1'b1;
    end
  end

  always_comb begin
    for (int s = 0; s < MAXK; s++) begin
      nxt_vld[s] = 1'b0;
      nxt_rk[s]  = '0;
      for (int l = 0; l < LANES; l++) nxt_dat[s][l] = '0;
    end

    nxt_vld[0] = accept;
    nxt_rk[0]  = (k_eff != '0) ? k_eff - KW'(1) : '0;
    for (int l = 0; l < LANES; l++) begin
      nxt_dat[0][l] = (k_eff != '0) ? halve(in_x[l*LOGQ +: LOGQ], half_q1)
                                     : in_x[l*LOGQ +: LOGQ];
    end

    for (int s = 1; s < MAXK; s++) begin
      nxt_vld[s] = vld[s-1];
      nxt_rk[s]  = (rk[s-1] != '0) ? rk[s-1] - KW'(1) : '0;
      for (int l = 0; l < LANES; l++) begin
        nxt_dat[s][l] = (rk[s-1] != '0) ? halve(dat[s-1][l], half_q1)
                                         : dat[s-1][l];
      end
    end
  end

  // The whole pipe moves in lockstep; bubbles are kept, not collapsed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < MAXK; s++) begin
        vld[s] <= 1'b0;
        rk[s]  <= '0;
        for (int l = 0; l < LANES; l++) dat[s][l] <= '0;
      end
    end else if (adv) begin
      for (int s = 0; s < MAXK; s++) begin
        vld[s] <= nxt_vld[s];
        rk[s]  <= nxt_rk[s];
        for (int l = 0; l < LANES; l++) dat[s][l] <= nxt_dat[s][l];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (accept && (x_over || k_over)) begin
      err <= 1'b1;
    end
  end

  assign out_valid = vld[MAXK-1];

  for (genvar l = 0; l < LANES; l++) begin : g_out
    assign out_y[l*LOGQ +: LOGQ] = dat[MAXK-1][l];
  end

endmodule
